// File: rtl/uart_reg_frame_gen_pkg.sv
// Shared definitions for the register UART frame generator: FSM states,
// default header constant and index sizing.
package uart_reg_frame_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HEAD = 2'd1,
    ST_DATA = 2'd2,
    ST_SUM  = 2'd3
  } state_t;

  localparam int SEQ_W = 8;
  localparam logic [31:0] DEFAULT_HEADER = 32'h55AA_A500;

  // Register index width, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_frame_timer.sv
// Free-running period counter producing a one-cycle tick on its terminal
// count; a zero period disables it entirely.
module uart_frame_timer #(
  parameter int CLK_FRE   = 50,
  parameter int PERIOD_MS = 100
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int PERIOD_CYC = CLK_FRE * 1000 * PERIOD_MS;
  localparam int CNT_W      = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'((PERIOD_CYC > 0) ? PERIOD_CYC - 1 : 0);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (PERIOD_CYC == 0 || r_cnt == TERM) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = (PERIOD_CYC != 0) && (r_cnt == TERM);

endmodule

// File: rtl/uart_reg_frame_gen.sv
// Snapshots a register bank on a trigger or timer tick and streams it as
// header, data words and a data-only checksum over a valid/ready port.
module uart_reg_frame_gen
  import uart_reg_frame_gen_pkg::*;
#(
  parameter int CLK_FRE   = 50,
  parameter int PERIOD_MS = 100,
  parameter int REG_WIDTH = 32,
  parameter int REG_NUM   = 4,
  parameter logic [REG_WIDTH-1:0] HEADER = REG_WIDTH'(DEFAULT_HEADER)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         trig,
  input  logic [REG_NUM*REG_WIDTH-1:0] reg_bus,
  output logic [REG_WIDTH-1:0]         frame_tx_reg,
  output logic                         frame_tx_valid,
  input  logic                         frame_tx_ready,
  output logic                         busy,
  output logic                         frame_done,
  output logic                         frame_drop
);

  localparam int IDX_W = idx_width(REG_NUM);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(REG_NUM - 1);

  state_t               r_state, w_state_next;
  logic [REG_WIDTH-1:0] r_shadow [REG_NUM];
  logic [REG_WIDTH-1:0] r_sum, w_sum_next;
  logic [REG_WIDTH-1:0] r_word, w_word_next;
  logic [REG_WIDTH-1:0] w_data_sum;
  logic [IDX_W-1:0]     r_idx, w_idx_next, w_idx_inc;
  logic [SEQ_W-1:0]     r_seq, w_seq_next;
  logic                 r_pend, w_pend_next;
  logic                 r_valid, w_valid_next;
  logic                 r_busy, w_busy_next;
  logic                 r_done, w_done_next;
  logic                 r_drop, w_drop_next;
  logic                 w_snap, w_tick, w_req, w_hs;

  uart_frame_timer #(
    .CLK_FRE   (CLK_FRE),
    .PERIOD_MS (PERIOD_MS)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (w_tick)
  );

  assign w_req      = trig | w_tick;
  assign w_hs       = r_valid & frame_tx_ready;
  assign w_idx_inc  = r_idx + 1'b1;
  assign w_data_sum = r_sum + r_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_sum_next   = r_sum;
    w_word_next  = r_word;
    w_idx_next   = r_idx;
    w_seq_next   = r_seq;
    w_pend_next  = r_pend;
    w_valid_next = r_valid;
    w_busy_next  = r_busy;
    w_done_next  = 1'b0;
    w_drop_next  = 1'b0;
    w_snap       = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (w_req || r_pend) begin
          w_snap       = 1'b1;
          w_sum_next   = '0;
          w_idx_next   = '0;
          w_pend_next  = 1'b0;
          w_word_next  = {HEADER[REG_WIDTH-1:SEQ_W], r_seq};
          w_valid_next = 1'b1;
          w_busy_next  = 1'b1;
          w_state_next = ST_HEAD;
        end
      end
      ST_HEAD: begin
        if (w_hs) begin
          w_word_next  = r_shadow[0];
          w_state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_hs) begin
          w_sum_next = w_data_sum;
          if (r_idx == LAST_IDX) begin
            w_word_next  = w_data_sum;
            w_state_next = ST_SUM;
          end else begin
            w_idx_next  = w_idx_inc;
            w_word_next = r_shadow[w_idx_inc];
          end
        end
      end
      ST_SUM: begin
        if (w_hs) begin
          w_valid_next = 1'b0;
          w_busy_next  = 1'b0;
          w_done_next  = 1'b1;
          w_seq_next   = r_seq + 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase

    // Only one request may wait behind the running frame; extras are dropped.
    if (r_busy && w_req) begin
      if (!r_pend) w_pend_next = 1'b1;
      else         w_drop_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum   <= '0;
      r_word  <= '0;
      r_idx   <= '0;
      r_seq   <= '0;
      r_pend  <= 1'b0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_sum   <= w_sum_next;
      r_word  <= w_word_next;
      r_idx   <= w_idx_next;
      r_seq   <= w_seq_next;
      r_pend  <= w_pend_next;
      r_valid <= w_valid_next;
      r_busy  <= w_busy_next;
      r_done  <= w_done_next;
      r_drop  <= w_drop_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_NUM; i++) r_shadow[i] <= '0;
    end else if (w_snap) begin
      for (int i = 0; i < REG_NUM; i++) r_shadow[i] <= reg_bus[i*REG_WIDTH +: REG_WIDTH];
    end
  end

  assign frame_tx_reg   = r_word;
  assign frame_tx_valid = r_valid;
  assign busy           = r_busy;
  assign frame_done     = r_done;
  assign frame_drop     = r_drop;

endmodule
